mem_load_unit: RTL and testbench

Multicycle load-capture stage sitting directly upstream of the write-back MemToReg selector. When the control unit issues a load, the block holds a read strobe to data memory for a fixed latency and captures the returned word. It then extracts the addressed byte, halfword or word, sign- or zero-extends it to 32 bits, and holds the result in its memory data register (MDR). The MDR output feeds the MemToReg mux data input for the register-file write-back cycle.

---
 rtl/mem_load_unit.sv | 130 +++++++++++++
 tb/tb_mem_load_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_load_unit.sv
// Multicycle load-capture stage: strobes data memory for MEM_LAT cycles, then
// extracts/extends the addressed byte, halfword or word into the MDR.
module mem_load_unit #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_rdata,
    output logic        mem_rd,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] mdr_out
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    addr_q, addr_d;
    logic [31:0]   mdr_q, mdr_d;
    logic          mis_q, mis_d;

    logic          req_bad;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;

    // Halves must be 2-byte aligned; words (and the 11 encoding) 4-byte aligned.
    assign req_bad = ((size == 2'b01) && addr_lo[0]) ||
                     (size[1] && (addr_lo != 2'b00));

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = uns_q ? {16'b0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        mdr_d   = mdr_q;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        mis_d = 1'b1;
                    end else begin
                        size_d  = size;
                        uns_d   = unsigned_ld;
                        addr_d  = addr_lo;
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    mdr_d   = load_val;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            mdr_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            mdr_q   <= mdr_d;
            mis_q   <= mis_d;
        end
    end

    assign mem_rd     = (state_q == S_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign misaligned = mis_q;
    assign mdr_out    = mdr_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed self-checking bench for mem_load_unit with MEM_LAT=2.
module tb_mem_load_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [1:0]  addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] mdr_out;

    int checks = 0;
    int errors = 0;

    mem_load_unit #(.MEM_LAT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .addr_lo    (addr_lo),
        .mem_rdata  (mem_rdata),
        .mem_rd     (mem_rd),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .mdr_out    (mdr_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one aligned load, count strobe cycles and the done latency, check the MDR.
    task automatic load(input string tag, input logic [1:0] sz, input logic u,
                        input logic [1:0] a, input logic [31:0] data,
                        input logic [31:0] exp);
        int rd_cnt;
        int done_at;
        @(negedge clk);
        size = sz; unsigned_ld = u; addr_lo = a; mem_rdata = data; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rd_cnt = 0;
        done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            if (mem_rd) rd_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_rd_cycles"}, 32'(rd_cnt), 32'd2);
        check({tag, "_done_at"}, 32'(done_at), 32'd3);
        check({tag, "_mdr"}, mdr_out, exp);
        @(negedge clk);
    endtask

    initial begin
        int spurious;
        reset = 1'b1; start = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr_lo = 2'b00; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_mis", {31'b0, misaligned}, 32'h0);

        load("word0", 2'b10, 1'b0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF);

        load("sb0", 2'b00, 1'b0, 2'd0, 32'h80FF7F01, 32'h00000001);
        load("sb1", 2'b00, 1'b0, 2'd1, 32'h80FF7F01, 32'h0000007F);
        load("sb2", 2'b00, 1'b0, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF);
        load("sb3", 2'b00, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80);
        load("ub0", 2'b00, 1'b1, 2'd0, 32'h80FF7F01, 32'h00000001);
        load("ub1", 2'b00, 1'b1, 2'd1, 32'h80FF7F01, 32'h0000007F);
        load("ub2", 2'b00, 1'b1, 2'd2, 32'h80FF7F01, 32'h000000FF);
        load("ub3", 2'b00, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080);

        load("sh2", 2'b01, 1'b0, 2'd2, 32'h8001F00F, 32'hFFFF8001);
        load("uh0", 2'b01, 1'b1, 2'd0, 32'h8001F00F, 32'h0000F00F);
        load("w11u", 2'b11, 1'b1, 2'd0, 32'hF0000001, 32'hF0000001);

        load("w_pre", 2'b10, 1'b0, 2'd0, 32'h12345678, 32'h12345678);
        @(negedge clk);
        size = 2'b10; addr_lo = 2'd1; mem_rdata = 32'hCAFEF00D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mis_pulse", {31'b0, misaligned}, 32'h1);
        check("mis_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("mis_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        check("mis_pulse_end", {31'b0, misaligned}, 32'h0);
        check("mis_mdr", mdr_out, 32'h12345678);
        check("mis_idle_rd", {31'b0, mem_rd}, 32'h0);

        // start held through WAIT and DONE: only the first must be accepted
        size = 2'b10; addr_lo = 2'd0; mem_rdata = 32'h0BADF00D; start = 1'b1;
        @(negedge clk);
        check("hold_wait1", {31'b0, mem_rd}, 32'h1);
        @(negedge clk);
        check("hold_wait2", {31'b0, mem_rd}, 32'h1);
        @(negedge clk);
        check("hold_done", {31'b0, done}, 32'h1);
        check("hold_mdr", mdr_out, 32'h0BADF00D);
        start = 1'b0;
        spurious = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_rd || busy || done) spurious++;
        end
        check("hold_no_second", 32'(spurious), 32'd0);

        // reset during WAIT with start also asserted
        size = 2'b10; addr_lo = 2'd0; mem_rdata = 32'h55AA55AA; start = 1'b1;
        @(negedge clk);
        check("abort_in_wait", {31'b0, mem_rd}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_mdr", mdr_out, 32'h0);
        reset = 1'b0; start = 1'b0;
        spurious = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || mem_rd || busy) spurious++;
        end
        check("abort_no_done", 32'(spurious), 32'd0);
        check("abort_mdr_kept", mdr_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
